mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WIDTH, default 32, data width.
REQ-002 Parameter ADDR_LEN, default 32, address and PC width.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 ex_valid  in  1  EX-MEM entry presented.
REQ-006 ex_ready  out  1  stage accepts the entry this cycle.
REQ-007 ex_pc  in  ADDR_LEN  PC of the instruction.
REQ-008 ex_alu_out  in  WIDTH  ALU result, which is also the effective address.
REQ-009 ex_rs2_data  in  WIDTH  store data.
REQ-010 ex_mem_op  in  2  MEM_OP_NONE/LOAD/STORE.
REQ-011 ex_mem_size  in  2  SIZE_BYTE/HALF/WORD.
REQ-012 ex_mem_unsigned  in  1  zero-extend loads when 1.
REQ-013 ex_rd  in  5  destination register; ex_rd_we  in  1  writes rd.
REQ-014 dmem_req  out  1  memory request, held until acknowledged.
REQ-015 dmem_we  out  1  1 = store.
REQ-016 dmem_addr  out  ADDR_LEN  word-aligned address (low 2 bits zero).
REQ-017 dmem_wdata  out  WIDTH  lane-replicated store data.
REQ-018 dmem_be  out  4  byte enables.
REQ-019 dmem_ack  in  1  request complete; dmem_rdata  in  WIDTH  load word, valid with ack.
REQ-020 wb_valid, wb_we, wb_misaligned  out  1 each  MEM-WB register outputs.
REQ-021 wb_pc  out  ADDR_LEN; wb_result  out  WIDTH; wb_rd  out  5  MEM-WB register outputs.

Function
REQ-022 The FSM SHALL have states IDLE and BUSY; ex_ready SHALL be 1 only in IDLE.
REQ-023 An entry is accepted when ex_valid=1 and ex_ready=1.
REQ-024 An accepted NONE op SHALL produce, on the next edge: wb_valid=1, wb_result=ex_alu_out, wb_pc/wb_rd/wb_we from the entry; the state SHALL stay IDLE.
REQ-025 An accepted aligned LOAD or STORE SHALL latch address, data, size and signedness, and enter BUSY.
REQ-026 In BUSY, dmem_req SHALL be 1 with stable outputs; it SHALL be 0 in IDLE.
REQ-027 dmem_ack in BUSY SHALL cause, on that edge: return to IDLE, plus a wb_valid pulse the following cycle; an ack in IDLE SHALL be ignored.
REQ-028 An ack in the first BUSY cycle is legal, giving a minimum memory-op latency of accept+2 cycles to wb_valid.
REQ-029 Alignment: HALF requires addr[0]=0; WORD requires addr[1:0]=0; BYTE is always aligned.
REQ-030 A misaligned access SHALL issue no request and produce wb_valid=1, wb_misaligned=1, wb_we=0 on the next edge, with wb_result=address.
REQ-031 Byte enables: BYTE = 1<<addr[1:0]; HALF = 4'b0011 or 4'b1100 per addr[1]; WORD = 4'b1111.
REQ-032 Store data: byte replicated x4; half replicated x2; word unchanged.
REQ-033 Load data SHALL select the lane by addr[1:0], then sign- or zero-extend per ex_mem_unsigned; WORD ignores the unsigned flag.
REQ-034 Stores SHALL complete with wb_we=0 and wb_result=0.
REQ-035 wb_valid SHALL be a single-cycle pulse per instruction; wb_misaligned SHALL be 0 except as REQ-030 specifies.

Reset
REQ-036 Reset SHALL force IDLE and drive all outputs to 0, except ex_ready, which is 1 after reset.
REQ-037 Reset during BUSY SHALL drop dmem_req immediately, abandon the access, and emit no wb_valid.

Structure
REQ-038 MEM_OP_* and SIZE_* encodings and the FSM state encodings SHALL live in the shared defines file next to the OPSEL_* and ALU function codes.
REQ-039 The lane logic (REQ-031 to REQ-033) SHALL be the combinational sub-module mem_align.

Verification
REQ-040 NONE op, alu_out=0x1234 -> next cycle wb_valid=1, wb_result=0x1234, dmem_req never asserted.
REQ-041 Signed LB at 0x103 with rdata=0x80FFFFFF -> be unused, wb_result=0xFFFFFF80; repeated unsigned -> 0x00000080.
REQ-042 SH at 0x102 with rs2=0xABCD1234 -> dmem_addr=0x100, be=4'b1100, wdata=0x12341234, wb_we=0.
REQ-043 LW at 0x201 -> no dmem_req; next cycle wb_misaligned=1, wb_result=0x201.
REQ-044 LW with ack delayed 3 cycles, ex_valid held -> ex_ready=0 throughout BUSY, dmem_req stable, exactly one wb_valid.
REQ-045 Reset asserted mid-BUSY, then ack -> dmem_req=0 asynchronously, no wb_valid, ex_ready=1 after release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared defines for the pipeline: operand-select and ALU function codes,
// memory op / access size encodings and the MEM stage FSM states.
package mem_stage_pkg;

  // Operand select codes
  localparam logic [1:0] OPSEL_RS   = 2'd0;
  localparam logic [1:0] OPSEL_IMM  = 2'd1;
  localparam logic [1:0] OPSEL_PC   = 2'd2;
  localparam logic [1:0] OPSEL_ZERO = 2'd3;

  // ALU function codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Memory operation (2'b11 is unused and behaves as NONE)
  localparam logic [1:0] MEM_OP_NONE  = 2'd0;
  localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
  localparam logic [1:0] MEM_OP_STORE = 2'd2;

  // Access size (2'b11 is unused and behaves as WORD)
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    MEM_ST_IDLE = 1'b0,
    MEM_ST_BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic for the MEM stage (purely combinational).
// Ports:
//   addr_lo      low two address bits of the access
//   size         SIZE_* access size
//   is_unsigned  zero-extend loaded byte/half when 1
//   store_data   register value to be stored
//   load_word    full word returned by memory
//   be           byte enables for the access
//   wdata        lane-replicated store data
//   load_data    selected and extended load result
//   misaligned   access violates its natural alignment
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       addr_lo,
  input  logic [1:0]       size,
  input  logic             is_unsigned,
  input  logic [WIDTH-1:0] store_data,
  input  logic [WIDTH-1:0] load_word,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic             misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = load_word[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = load_word;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SIZE_HALF: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: accepts one EX-MEM entry at a time, runs loads and
// stores against a req/ack data memory and produces the MEM-WB register.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ex_*                EX-MEM entry (valid/ready handshake)
//   dmem_*              data memory request, held until dmem_ack
//   wb_*                MEM-WB register, wb_valid pulses once per instruction
//
// state | meaning
// IDLE  | ready for an entry; NONE and misaligned ops retire from here
// BUSY  | memory request outstanding, waiting for dmem_ack
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [ADDR_LEN-1:0] ex_pc,
  input  logic [WIDTH-1:0]    ex_alu_out,
  input  logic [WIDTH-1:0]    ex_rs2_data,
  input  logic [1:0]          ex_mem_op,
  input  logic [1:0]          ex_mem_size,
  input  logic                ex_mem_unsigned,
  input  logic [4:0]          ex_rd,
  input  logic                ex_rd_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [WIDTH-1:0]    dmem_wdata,
  output logic [3:0]          dmem_be,
  input  logic                dmem_ack,
  input  logic [WIDTH-1:0]    dmem_rdata,
  output logic                wb_valid,
  output logic                wb_we,
  output logic                wb_misaligned,
  output logic [ADDR_LEN-1:0] wb_pc,
  output logic [WIDTH-1:0]    wb_result,
  output logic [4:0]          wb_rd
);

  mem_state_t state, state_next;

  logic                accept, busy, is_mem;
  logic [ADDR_LEN-1:0] lat_addr, lat_pc;
  logic [WIDTH-1:0]    lat_wdata;
  logic [3:0]          lat_be;
  logic [1:0]          lat_size;
  logic                lat_unsigned, lat_store, lat_rd_we;
  logic [4:0]          lat_rd;

  logic [1:0]          al_addr_lo, al_size;
  logic                al_unsigned, al_misaligned;
  logic [3:0]          al_be;
  logic [WIDTH-1:0]    al_wdata, al_load_data;

  assign busy   = (state == MEM_ST_BUSY);
  assign is_mem = (ex_mem_op == MEM_OP_LOAD) || (ex_mem_op == MEM_OP_STORE);
  assign accept = ex_valid && ex_ready;

  // Lane logic looks at the incoming entry while idle and at the latched
  // access while the request is outstanding (for load extraction).
  assign al_addr_lo  = busy ? lat_addr[1:0] : ex_alu_out[1:0];
  assign al_size     = busy ? lat_size      : ex_mem_size;
  assign al_unsigned = busy ? lat_unsigned  : ex_mem_unsigned;

  mem_align #(.WIDTH(WIDTH)) u_align (
    .addr_lo     (al_addr_lo),
    .size        (al_size),
    .is_unsigned (al_unsigned),
    .store_data  (ex_rs2_data),
    .load_word   (dmem_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .load_data   (al_load_data),
    .misaligned  (al_misaligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MEM_ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ex_ready   = 1'b0;
    dmem_req   = 1'b0;
    case (state)
      MEM_ST_IDLE: begin
        ex_ready = 1'b1;
        if (ex_valid && is_mem && !al_misaligned) state_next = MEM_ST_BUSY;
      end
      MEM_ST_BUSY: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_next = MEM_ST_IDLE;
      end
      default: state_next = MEM_ST_IDLE;
    endcase
  end

  // Request outputs are zero whenever no access is outstanding.
  assign dmem_we    = busy & lat_store;
  assign dmem_addr  = busy ? {lat_addr[ADDR_LEN-1:2], 2'b00} : '0;
  assign dmem_wdata = busy ? lat_wdata : '0;
  assign dmem_be    = busy ? lat_be : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr      <= '0;
      lat_pc        <= '0;
      lat_wdata     <= '0;
      lat_be        <= '0;
      lat_size      <= '0;
      lat_unsigned  <= 1'b0;
      lat_store     <= 1'b0;
      lat_rd_we     <= 1'b0;
      lat_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_we         <= 1'b0;
      wb_misaligned <= 1'b0;
      wb_pc         <= '0;
      wb_result     <= '0;
      wb_rd         <= '0;
    end else begin
      wb_valid      <= 1'b0;
      wb_misaligned <= 1'b0;
      if (accept) begin
        if (!is_mem || al_misaligned) begin
          // Retires straight from IDLE; a misaligned access reports its address.
          wb_valid      <= 1'b1;
          wb_misaligned <= is_mem;
          wb_we         <= is_mem ? 1'b0 : ex_rd_we;
          wb_pc         <= ex_pc;
          wb_rd         <= ex_rd;
          wb_result     <= ex_alu_out;
        end else begin
          lat_addr     <= ex_alu_out[ADDR_LEN-1:0];
          lat_pc       <= ex_pc;
          lat_wdata    <= al_wdata;
          lat_be       <= al_be;
          lat_size     <= ex_mem_size;
          lat_unsigned <= ex_mem_unsigned;
          lat_store    <= (ex_mem_op == MEM_OP_STORE);
          lat_rd_we    <= ex_rd_we;
          lat_rd       <= ex_rd;
        end
      end else if (busy && dmem_ack) begin
        wb_valid  <= 1'b1;
        wb_we     <= lat_store ? 1'b0 : lat_rd_we;
        wb_pc     <= lat_pc;
        wb_rd     <= lat_rd;
        wb_result <= lat_store ? '0 : al_load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_alu_out, ex_rs2_data;
  logic [1:0]  ex_mem_op, ex_mem_size;
  logic        ex_mem_unsigned;
  logic [4:0]  ex_rd;
  logic        ex_rd_we;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we, wb_misaligned;
  logic [31:0] wb_pc, wb_result;
  logic [4:0]  wb_rd;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage #(.WIDTH(32), .ADDR_LEN(32)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
    .ex_mem_op(ex_mem_op), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_misaligned(wb_misaligned),
    .wb_pc(wb_pc), .wb_result(wb_result), .wb_rd(wb_rd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Scramble the entry fields (used while the stage must ignore them).
  task automatic scramble_ex();
    ex_pc           = $urandom;
    ex_alu_out      = $urandom;
    ex_rs2_data     = $urandom;
    ex_mem_op       = 2'($urandom_range(0, 2));
    ex_mem_size     = 2'($urandom_range(0, 2));
    ex_mem_unsigned = 1'($urandom_range(0, 1));
    ex_rd           = 5'($urandom);
    ex_rd_we        = 1'($urandom_range(0, 1));
  endtask

  // Issue one instruction at a negedge with the stage idle, then follow it
  // to retirement checking the request and the MEM-WB outputs.
  // op: 0 none, 1 load, 2 store; sz: 0 byte, 1 half, 2 word.
  task automatic do_op(input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input int op, input int sz,
                       input logic uns, input logic [4:0] rd, input logic rdwe,
                       input int dly, input logic [31:0] rdata, input logic hold);
    int          nbytes, idx;
    logic        mis;
    logic [31:0] exp_be, exp_wd, exp_res, lane;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis    = (op != 0) && ((alu % nbytes) != 0);
    idx    = alu % 4;

    check("ready_before_issue", ex_ready, 1);
    ex_valid = 1; ex_pc = pc; ex_alu_out = alu; ex_rs2_data = rs2;
    ex_mem_op = 2'(op); ex_mem_size = 2'(sz); ex_mem_unsigned = uns;
    ex_rd = rd; ex_rd_we = rdwe;
    @(negedge clk);

    if (op == 0 || mis) begin
      ex_valid = 0;
      check("direct_wb_valid", wb_valid, 1);
      check("direct_wb_misaligned", wb_misaligned, mis);
      check("direct_wb_we", wb_we, mis ? 1'b0 : rdwe);
      check("direct_wb_result", wb_result, alu);
      check("direct_wb_pc", wb_pc, pc);
      check("direct_wb_rd", wb_rd, rd);
      check("direct_no_req", dmem_req, 0);
      @(negedge clk);
      check("direct_wb_pulse", wb_valid, 0);
      return;
    end

    if (sz == 0) begin
      exp_be = 32'd1 << idx;
      exp_wd = (rs2 & 32'hFF) * 32'h01010101;
    end else if (sz == 1) begin
      exp_be = 32'd3 << idx;
      exp_wd = (rs2 & 32'hFFFF) * 32'h00010001;
    end else begin
      exp_be = 32'hF;
      exp_wd = rs2;
    end
    lane = (rdata >> (8 * idx));
    if (sz == 0) begin
      lane = lane & 32'hFF;
      if (!uns && lane >= 32'h80) lane = lane - 32'h100;
    end else if (sz == 1) begin
      lane = lane & 32'hFFFF;
      if (!uns && lane >= 32'h8000) lane = lane - 32'h10000;
    end
    exp_res = (op == 2) ? 32'd0 : lane;

    ex_valid = hold;
    if (hold) scramble_ex();
    for (int i = 0; i <= dly; i++) begin
      check("busy_req", dmem_req, 1);
      check("busy_ready", ex_ready, 0);
      check("busy_addr", dmem_addr, alu - (alu % 4));
      check("busy_we", dmem_we, op == 2);
      check("busy_be", dmem_be, exp_be);
      if (op == 2) check("busy_wdata", dmem_wdata, exp_wd);
      check("busy_no_wb", wb_valid, 0);
      if (i == dly) begin
        dmem_ack = 1; dmem_rdata = rdata; ex_valid = 0;
      end else if (hold) begin
        scramble_ex();
      end
      @(negedge clk);
    end
    dmem_ack = 0; dmem_rdata = $urandom;
    check("done_wb_valid", wb_valid, 1);
    check("done_wb_result", wb_result, exp_res);
    check("done_wb_we", wb_we, (op == 2) ? 1'b0 : rdwe);
    check("done_wb_pc", wb_pc, pc);
    check("done_wb_rd", wb_rd, rd);
    check("done_wb_misaligned", wb_misaligned, 0);
    check("done_req_dropped", dmem_req, 0);
    @(negedge clk);
    check("done_wb_pulse", wb_valid, 0);
  endtask

  initial begin
    reset = 1; ex_valid = 0; dmem_ack = 0; dmem_rdata = 0;
    ex_pc = 0; ex_alu_out = 0; ex_rs2_data = 0; ex_mem_op = 0; ex_mem_size = 0;
    ex_mem_unsigned = 0; ex_rd = 0; ex_rd_we = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", ex_ready, 1);
    check("rst_req", dmem_req, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_result", wb_result, 0);
    check("rst_wb_misaligned", wb_misaligned, 0);
    reset = 0;
    @(negedge clk);

    // Directed cases
    do_op(32'h40, 32'h1234, 32'h0, 0, 2, 0, 5'd3, 1, 0, 0, 0);
    do_op(32'h44, 32'h103, 32'h0, 1, 0, 0, 5'd4, 1, 0, 32'h80FFFFFF, 0);
    check("lb_signed", wb_result, 32'hFFFFFF80);
    do_op(32'h48, 32'h103, 32'h0, 1, 0, 1, 5'd4, 1, 1, 32'h80FFFFFF, 0);
    check("lbu", wb_result, 32'h00000080);
    do_op(32'h4C, 32'h102, 32'hABCD1234, 2, 1, 0, 5'd0, 0, 0, 0, 0);
    do_op(32'h50, 32'h201, 32'h0, 1, 2, 0, 5'd7, 1, 0, 0, 0);
    do_op(32'h54, 32'h200, 32'h0, 1, 2, 0, 5'd8, 1, 3, 32'hCAFEF00D, 1);

    // Ack while idle is ignored
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    check("idle_ack_ignored", wb_valid, 0);
    check("idle_ack_ready", ex_ready, 1);

    // Reset in the middle of an outstanding load
    ex_valid = 1; ex_pc = 32'h60; ex_alu_out = 32'h300; ex_mem_op = 1;
    ex_mem_size = 2; ex_rd = 5'd9; ex_rd_we = 1;
    @(negedge clk);
    ex_valid = 0;
    check("rstbusy_req_before", dmem_req, 1);
    #2 reset = 1;
    #1 check("rstbusy_req_async", dmem_req, 0);
    dmem_ack = 1; dmem_rdata = 32'h12345678;
    @(negedge clk);
    reset = 0;
    check("rstbusy_no_wb", wb_valid, 0);
    @(negedge clk);
    dmem_ack = 0;
    check("rstbusy_ready", ex_ready, 1);
    check("rstbusy_no_wb2", wb_valid, 0);
    @(negedge clk);
    check("rstbusy_no_wb3", wb_valid, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        dmem_ack = 1;
        @(negedge clk);
        dmem_ack = 0;
        check("rand_idle_ack", wb_valid, 0);
      end
      do_op($urandom, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
            1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
